pacman_soc_block_reader: RTL and testbench

//  Avalon-MM pipelined read master that fetches a block of LENGTH consecutive 32-bit words

---
 rtl/pacman_soc_block_reader.sv | 177 +++++++++++++++++
 tb/tb_pacman_soc_block_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_soc_block_reader.sv
// Block reader: Avalon-MM pipelined read master that fetches LENGTH consecutive
// words starting at a base word address and streams them out on valid/ready.
// Reads are issued only when the output FIFO is guaranteed to have room for the
// returning data (outstanding reads plus stored words never exceed FIFO_DEPTH).
module pacman_soc_block_reader #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned MAX_PEND   = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OCC_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_ZERO
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    issued;
    logic [PEND_W-1:0]   pending;
    logic [CNT_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic [OCC_W-1:0]    occupancy;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic                read_accept;
    logic                push;
    logic                pop;
    logic                last_pop;
    logic                done_r;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_count = wr_ptr - rd_ptr;
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'(pending);

    // Issue decision uses only registered counts. Once asserted it cannot drop
    // during a stall: returns and pops only lower pending/occupancy.
    always_comb begin
        avm_read = 1'b0;
        if (state == ST_RUN &&
            issued < len_r &&
            pending < PEND_W'(MAX_PEND) &&
            occupancy < OCC_W'(FIFO_DEPTH)) begin
            avm_read = 1'b1;
        end
    end

    assign avm_byteenable = '1;
    assign read_accept    = avm_read & ~avm_waitrequest;

    // Returns outside an active block, or with nothing outstanding, are stray and dropped.
    assign push = avm_readdatavalid &&
                  (state == ST_RUN || state == ST_DRAIN) &&
                  (pending != '0);

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign pop       = out_valid & out_ready;

    // In DRAIN every read has been issued; the block ends when the only word
    // left is being taken and nothing is still in flight.
    assign last_pop = (state == ST_DRAIN) && (pending == '0) &&
                      (fifo_count == CNT_W'(1)) && out_ready;

    // Zero-length completion is registered; normal completion coincides with the last pop.
    assign done = done_r | last_pop;

    // Block control FSM: latches the request, steps the address and issued count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done_r      <= 1'b0;
            avm_address <= '0;
            len_r       <= '0;
            issued      <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        avm_address <= base_addr;
                        len_r       <= length;
                        issued      <= '0;
                        busy        <= 1'b1;
                        state       <= (length == '0) ? ST_ZERO : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (read_accept) begin
                        avm_address <= avm_address + ADDR_W'(1);
                        issued      <= issued + LEN_W'(1);
                        if (issued + LEN_W'(1) == len_r) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_pop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_ZERO: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    done_r <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding read counter: accept and return in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            unique case ({read_accept, push})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    // FIFO pointers; reset empties the FIFO without clearing storage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end

    // FIFO storage write of returning read data.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= avm_readdata;
        end
    end

endmodule

// File: tb/tb_pacman_soc_block_reader.sv
// Testbench for pacman_soc_block_reader: Avalon slave model with random stalls
// and latency, random consumer back-pressure, and an address/data reference model.
module tb_pacman_soc_block_reader;

    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned MAX_PEND   = 4;
    localparam int unsigned FIFO_DEPTH = 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [LEN_W-1:0]    length = '0;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest = 1'b0;
    logic [DATA_W-1:0]   avm_readdata = '0;
    logic                avm_readdatavalid = 1'b0;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;

    always #5 clk = ~clk;

    pacman_soc_block_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .MAX_PEND(MAX_PEND), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .avm_address(avm_address),
        .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int wait_pct = 0;
    int lat_min = 1;
    int lat_max = 1;
    int ready_pct = 100;
    bit stray_en = 1'b0;

    // Reference model: expected address sequence and word stream of the block.
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } resp_t;
    resp_t resp_q [$];

    int acc_cnt, ret_cnt, pop_cnt, done_cnt, done_cyc, read_cycles, last_due, t0;
    bit prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int len;
        int wait_pct;
        int lat_min;
        int lat_max;
        int ready_pct;
        int exp_done;
    } vec_t;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk_le(input string name, input longint act, input longint limit);
        checks++;
        if (act > limit) begin
            errors++;
            $display("FAIL %s: actual=%0d required<=%0d (cycle %0d)", name, act, limit, cyc);
        end
    endfunction

    // Per-cycle observation at the falling edge, when all of the cycle's values are settled.
    function automatic void monitor();
        resp_t r;
        int lat;
        if (!reset_n) begin
            resp_q.delete();
            prev_stall = 1'b0;
            last_due = 0;
            return;
        end
        if (avm_read) begin
            read_cycles++;
            chk("byteenable", avm_byteenable, 4'hF);
        end
        if (prev_stall) begin
            chk("stall_read_held", avm_read, 1);
            chk("stall_addr_held", avm_address, prev_addr);
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        if (avm_read && !avm_waitrequest) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_read: actual address 0x%0h, required no read (cycle %0d)", avm_address, cyc);
            end else begin
                chk("read_addr", avm_address, exp_addr.pop_front());
            end
            lat = int'($urandom_range(lat_max, lat_min));
            r.data = mem[avm_address];
            r.due  = cyc + lat;
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            resp_q.push_back(r);
            acc_cnt++;
        end
        if (out_valid && out_ready) begin
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: actual 0x%0h, required no word (cycle %0d)", out_data, cyc);
            end else begin
                chk("out_data", out_data, exp_data.pop_front());
            end
            pop_cnt++;
        end
        chk_le("pending_bound", acc_cnt - ret_cnt, MAX_PEND);
        chk_le("fifo_bound", acc_cnt - pop_cnt, FIFO_DEPTH);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_all_words", exp_data.size(), 0);
        end
    endfunction

    // Slave and consumer: drive inputs just after the rising edge, observe at the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            avm_waitrequest = (int'($urandom_range(99)) < wait_pct);
            out_ready       = (int'($urandom_range(99)) < ready_pct);
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = resp_q[0].data;
                void'(resp_q.pop_front());
                ret_cnt++;
            end else begin
                avm_readdatavalid = stray_en;
                avm_readdata      = $urandom;
            end
            @(negedge clk);
            monitor();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic begin_block(input logic [ADDR_W-1:0] base, input int len);
        logic [ADDR_W-1:0] a;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < len; i++) begin
            a = base + ADDR_W'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
        end
        acc_cnt = 0; ret_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1; read_cycles = 0;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        length = LEN_W'(len);
        t0 = cyc;
        // Start stays high one more cycle with junk operands; it must be ignored.
        @(posedge clk); #1;
        base_addr = ADDR_W'($urandom);
        length = LEN_W'($urandom);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_block(input int exp_rel, input int len);
        for (int k = 0; k < 4000 && done_cnt == 0; k++) @(posedge clk);
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: actual no done, required done within 4000 cycles");
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("words_left", exp_data.size(), 0);
        chk("reads_left", exp_addr.size(), 0);
        chk("reads_accepted", acc_cnt, len);
        chk("busy_idle", busy, 0);
        if (exp_rel >= 0) chk("done_latency", done_cyc - t0, exp_rel);
        if (wait_pct == 0) chk("read_cycles", read_cycles, len);
    endtask

    task automatic run_vec(input vec_t v);
        wait_pct = v.wait_pct;
        lat_min = v.lat_min;
        lat_max = v.lat_max;
        ready_pct = v.ready_pct;
        begin_block(v.base, v.len);
        finish_block(v.exp_done, v.len);
    endtask

    initial begin
        vec_t vecs [8];
        vec_t v;
        vecs[0] = '{15'h0010,  4,  0, 1, 1, 100,  6};
        vecs[1] = '{15'h1234,  0,  0, 1, 1, 100,  2};
        vecs[2] = '{15'h7FFE,  4,  0, 1, 1, 100,  6};
        vecs[3] = '{15'h0100,  1,  0, 1, 1, 100,  3};
        vecs[4] = '{15'h0200, 16,  0, 1, 1, 100, 18};
        vecs[5] = '{15'h7FF0, 64, 50, 1, 3,  50, -1};
        vecs[6] = '{15'h3000, 40, 30, 1, 3, 100, -1};
        vecs[7] = '{15'h4000, 33,  0, 2, 3,  70, -1};

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + 32'(i);

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_avm_read", avm_read, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_avm_address", avm_address, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Consumer stalled: only FIFO_DEPTH reads may be accepted.
        wait_pct = 0; lat_min = 1; lat_max = 1; ready_pct = 0;
        begin_block(15'h0500, 20);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("stalled_reads", acc_cnt, FIFO_DEPTH);
        chk("stalled_avm_read", avm_read, 0);
        ready_pct = 100;
        finish_block(-1, 20);

        // Stray returns while idle must not reach the stream.
        stray_en = 1'b1;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            chk("stray_out_valid", out_valid, 0);
        end
        stray_en = 1'b0;
        run_vec(vecs[0]);

        // Reset in the middle of a block.
        wait_pct = 0; lat_min = 2; lat_max = 2; ready_pct = 100;
        begin_block(15'h0800, 16);
        for (int k = 0; k < 200 && pop_cnt < 5; k++) @(posedge clk);
        chk("reset_point_reached", (pop_cnt >= 5), 1);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        acc_cnt = 0; ret_cnt = 0; pop_cnt = 0;
        @(negedge clk);
        chk("midreset_busy", busy, 0);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_avm_read", avm_read, 0);
        chk("midreset_done", done, 0);
        chk("midreset_done_count", done_cnt, 0);
        repeat (2) @(posedge clk);
        v = '{15'h0010, 2, 0, 1, 1, 100, 4};
        run_vec(v);

        // Randomized blocks.
        for (int n = 0; n < 6; n++) begin
            v.base = ADDR_W'($urandom);
            v.len = int'($urandom_range(40, 1));
            v.wait_pct = int'($urandom_range(60, 0));
            v.lat_min = 1;
            v.lat_max = int'($urandom_range(3, 1));
            v.ready_pct = int'($urandom_range(100, 30));
            v.exp_done = -1;
            run_vec(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
